// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: captures the EX result, store data and control bundle,
// with stall hold, flush bubble and a sticky HLT freeze for the MEM stage.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal operation: load, stall or flush each cycle
// HALTED  | a HLT has been captured; every register frozen until reset
module ex_mem_pipe_reg #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_ex_valid,
  input  logic          id_ex_regwrite,
  input  logic          id_ex_memread,
  input  logic          id_ex_memwrite,
  input  logic          id_ex_memtoreg,
  input  logic          id_ex_halt,
  input  logic [RW-1:0] id_ex_rd,
  input  logic [RW-1:0] id_ex_rs,
  input  logic [RW-1:0] id_ex_rt,
  input  logic [DW-1:0] ex_alu_result,
  input  logic [DW-1:0] ex_store_data,
  input  logic [DW-1:0] ex_pc_plus2,
  output logic          EX_MEM_valid,
  output logic          EX_MEM_regwrite,
  output logic          EX_MEM_memread,
  output logic          EX_MEM_memwrite,
  output logic          EX_MEM_memtoreg,
  output logic          EX_MEM_halt,
  output logic [RW-1:0] EX_MEM_rd,
  output logic [RW-1:0] EX_MEM_rs,
  output logic [RW-1:0] EX_MEM_rt,
  output logic [DW-1:0] EX_MEM_alu_result,
  output logic [DW-1:0] EX_MEM_store_data,
  output logic [DW-1:0] EX_MEM_pc_plus2,
  output logic          EX_MEM_fwd_valid,
  output logic          halted
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t state_q, state_d;

  logic          valid_q, regwrite_q, memread_q, memwrite_q, memtoreg_q, halt_q, fwd_valid_q;
  logic [RW-1:0] rd_q, rs_q, rt_q;
  logic [DW-1:0] alu_result_q, store_data_q, pc_plus2_q;

  logic          load_en;
  logic          fwd_valid_d;

  assign load_en     = (state_q == RUN) && !flush && !stall;
  assign fwd_valid_d = id_ex_valid && id_ex_regwrite && (id_ex_rd != '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (load_en && id_ex_valid && id_ex_halt) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      halt_q       <= 1'b0;
      fwd_valid_q  <= 1'b0;
      rd_q         <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      alu_result_q <= '0;
      store_data_q <= '0;
      pc_plus2_q   <= '0;
    end else if (state_q == HALTED) begin
      // frozen: EX_MEM_halt must keep showing the HLT downstream
    end else if (flush) begin
      valid_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      halt_q      <= 1'b0;
      fwd_valid_q <= 1'b0;
    end else if (!stall) begin
      // bubbles still carry data/specifiers, but never side-effecting control
      valid_q      <= id_ex_valid;
      regwrite_q   <= id_ex_valid & id_ex_regwrite;
      memread_q    <= id_ex_valid & id_ex_memread;
      memwrite_q   <= id_ex_valid & id_ex_memwrite;
      memtoreg_q   <= id_ex_memtoreg;
      halt_q       <= id_ex_valid & id_ex_halt;
      fwd_valid_q  <= fwd_valid_d;
      rd_q         <= id_ex_rd;
      rs_q         <= id_ex_rs;
      rt_q         <= id_ex_rt;
      alu_result_q <= ex_alu_result;
      store_data_q <= ex_store_data;
      pc_plus2_q   <= ex_pc_plus2;
    end
  end

  assign EX_MEM_valid      = valid_q;
  assign EX_MEM_regwrite   = regwrite_q;
  assign EX_MEM_memread    = memread_q;
  assign EX_MEM_memwrite   = memwrite_q;
  assign EX_MEM_memtoreg   = memtoreg_q;
  assign EX_MEM_halt       = halt_q;
  assign EX_MEM_rd         = rd_q;
  assign EX_MEM_rs         = rs_q;
  assign EX_MEM_rt         = rt_q;
  assign EX_MEM_alu_result = alu_result_q;
  assign EX_MEM_store_data = store_data_q;
  assign EX_MEM_pc_plus2   = pc_plus2_q;
  assign EX_MEM_fwd_valid  = fwd_valid_q;
  assign halted            = (state_q == HALTED);

endmodule
